// File: rtl/pixel_scan_gen_pkg.sv
// Shared GPU engine definitions: default frame geometry, scan FSM states and
// the counter width helper used to size the pixel/layer coordinate buses.
package gpu_pkg;

  localparam int X_MAX_DEF    = 1920;
  localparam int Y_MAX_DEF    = 1080;
  localparam int N_LAYERS_DEF = 4;
  localparam int FCNT_W_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A counter over n values needs at least one bit, even when n == 1.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_scan_gen_if.sv
// Beat stream from the scan generator to the compositing pipeline:
// one (layer, x, y) sample per accepted valid/ready transfer.
interface pixel_scan_gen_if #(
  parameter int LW = 2,
  parameter int XW = 11,
  parameter int YW = 11
);

  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] layer;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_end;
  logic          frame_end;

  modport master (
    output out_valid, layer, x, y, line_end, frame_end,
    input  out_ready
  );

  modport slave (
    input  out_valid, layer, x, y, line_end, frame_end,
    output out_ready
  );

endinterface

// File: rtl/pixel_scan_gen_wrap_counter.sv
// Modulo-(MAX+1) up counter. Wraps at MAX, never at 2^W, so non-power-of-two
// ranges stay within 0..MAX. at_max feeds the carry into the next axis.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  assign at_max = (value_q == MAX_V);
  assign value  = value_q;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/pixel_scan_gen.sv
// Layer/x/y scan generator: walks layer (innermost), then x, then y, one beat
// per accepted handshake, optionally looping frames back-to-back.
module pixel_scan_gen
  import gpu_pkg::*;
#(
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int N_LAYERS = N_LAYERS_DEF,
  parameter int FCNT_W   = FCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  pixel_scan_gen_if.master  bus,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int LW = width_of(N_LAYERS);
  localparam int XW = width_of(X_MAX);
  localparam int YW = width_of(Y_MAX);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic          accept;
  logic          layer_at_max, x_at_max, y_at_max;
  logic          x_inc, y_inc, last_beat, clr;
  logic [LW-1:0] layer_val;
  logic [XW-1:0] x_val;
  logic [YW-1:0] y_val;

  assign accept    = out_valid_q && bus.out_ready;
  assign x_inc     = accept && layer_at_max;
  assign y_inc     = x_inc && x_at_max;
  assign last_beat = y_inc && y_at_max;
  // Coordinates are parked at the origin whenever no frame is in progress.
  assign clr       = (state_q == IDLE);

  wrap_counter #(.MAX(N_LAYERS - 1), .W(LW)) u_layer_cnt (
    .clk(clk), .reset(reset), .inc(accept), .clr(clr),
    .value(layer_val), .at_max(layer_at_max)
  );

  wrap_counter #(.MAX(X_MAX - 1), .W(XW)) u_x_cnt (
    .clk(clk), .reset(reset), .inc(x_inc), .clr(clr),
    .value(x_val), .at_max(x_at_max)
  );

  wrap_counter #(.MAX(Y_MAX - 1), .W(YW)) u_y_cnt (
    .clk(clk), .reset(reset), .inc(y_inc), .clr(clr),
    .value(y_val), .at_max(y_at_max)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          out_valid_d = 1'b1;
        end
      end
      RUN: begin
        // Counters wrap to the origin on their own; cont only decides whether
        // the next frame follows immediately.
        if (last_beat) begin
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          if (!cont) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.layer     = layer_val;
  assign bus.x         = x_val;
  assign bus.y         = y_val;
  assign bus.line_end  = out_valid_q && layer_at_max && x_at_max;
  assign bus.frame_end = out_valid_q && layer_at_max && x_at_max && y_at_max;
  assign busy          = (state_q == RUN);
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Directed-plus-random bench for pixel_scan_gen: two configurations checked
// against a beat-index model (layer = b % L, x = (b / L) % X, y = b / (L*X)).
module tb_pixel_scan_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b;
  logic cont;
  logic rdy;

  int total = 0;
  int bad   = 0;

  // Config A: 2 layers, 4x3 frame. Config B: 1 layer, 5x2 frame.
  pixel_scan_gen_if #(.LW(1), .XW(2), .YW(2)) if_a ();
  pixel_scan_gen_if #(.LW(1), .XW(3), .YW(1)) if_b ();

  assign if_a.out_ready = rdy;
  assign if_b.out_ready = rdy;

  logic        busy_a, busy_b;
  logic [15:0] fcnt_a, fcnt_b;

  pixel_scan_gen #(.X_MAX(4), .Y_MAX(3), .N_LAYERS(2), .FCNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cont(cont),
    .bus(if_a), .busy(busy_a), .frame_cnt(fcnt_a)
  );

  pixel_scan_gen #(.X_MAX(5), .Y_MAX(2), .N_LAYERS(1), .FCNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cont(cont),
    .bus(if_b), .busy(busy_b), .frame_cnt(fcnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks n accepted beats of the selected DUT against the beat-index model.
  // A stalled cycle re-checks the same beat, so held outputs are verified too.
  task automatic run_beats(input bit sel, input int nl, input int xm, input int ym,
                           input int n, input bit rand_rdy, input bit rand_start);
    int b      = 0;
    int cycles = 0;
    int fl     = nl * xm * ym;
    int el, ex, ey;
    while (b < n && cycles < 8 * n + 50) begin
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rand_start) start_a = 1'($urandom_range(0, 1));
      el = b % nl;
      ex = (b / nl) % xm;
      ey = (b / (nl * xm)) % ym;
      check($sformatf("b%0d valid", b), sel ? if_b.out_valid : if_a.out_valid, 1);
      check($sformatf("b%0d layer", b), sel ? if_b.layer : if_a.layer, el);
      check($sformatf("b%0d x", b), sel ? if_b.x : if_a.x, ex);
      check($sformatf("b%0d y", b), sel ? if_b.y : if_a.y, ey);
      check($sformatf("b%0d line_end", b), sel ? if_b.line_end : if_a.line_end,
            ((b + 1) % (nl * xm)) == 0);
      check($sformatf("b%0d frame_end", b), sel ? if_b.frame_end : if_a.frame_end,
            ((b + 1) % fl) == 0);
      check($sformatf("b%0d busy", b), sel ? busy_b : busy_a, 1);
      tick();
      if (rdy) b++;
      cycles++;
    end
    start_a = 1'b0;
    rdy     = 1'b1;
    if (b < n) check("beat_timeout", b, n);
  endtask

  initial begin
    reset   = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    cont    = 1'b0;
    rdy     = 1'b1;

    // Reset held with start asserted
    repeat (3) tick();
    check("rst valid", if_a.out_valid, 0);
    check("rst layer", if_a.layer, 0);
    check("rst x", if_a.x, 0);
    check("rst y", if_a.y, 0);
    check("rst fcnt", fcnt_a, 0);
    check("rst busy", busy_a, 0);
    check("rst line_end", if_a.line_end, 0);
    check("rst frame_end", if_a.frame_end, 0);
    check("rst b valid", if_b.out_valid, 0);
    check("rst b busy", busy_b, 0);

    // IDLE holds without start
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) tick();
    check("idle valid", if_a.out_valid, 0);
    check("idle busy", busy_a, 0);

    // Single frame, no backpressure
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run_beats(1'b0, 2, 4, 3, 24, 1'b0, 1'b0);
    check("single end valid", if_a.out_valid, 0);
    check("single end busy", busy_a, 0);
    check("single fcnt", fcnt_a, 1);
    check("single end line_end", if_a.line_end, 0);
    tick();
    check("single idle valid", if_a.out_valid, 0);

    // Random backpressure; start toggling in RUN must not restart the frame
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run_beats(1'b0, 2, 4, 3, 24, 1'b1, 1'b1);
    check("bp end valid", if_a.out_valid, 0);
    check("bp fcnt", fcnt_a, 2);

    // Continuous mode from a fresh frame counter
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("cont pre fcnt", fcnt_a, 0);
    cont    = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run_beats(1'b0, 2, 4, 3, 48, 1'b0, 1'b0);
    check("cont valid", if_a.out_valid, 1);
    check("cont busy", busy_a, 1);
    check("cont fcnt", fcnt_a, 2);
    check("cont wrap layer", if_a.layer, 0);
    check("cont wrap x", if_a.x, 0);
    check("cont wrap y", if_a.y, 0);

    // Reset mid-frame at (layer, x, y) = (1, 2, 1)
    run_beats(1'b0, 2, 4, 3, 13, 1'b0, 1'b0);
    check("mid layer", if_a.layer, 1);
    check("mid x", if_a.x, 2);
    check("mid y", if_a.y, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cont  = 1'b0;
    check("midrst valid", if_a.out_valid, 0);
    check("midrst layer", if_a.layer, 0);
    check("midrst x", if_a.x, 0);
    check("midrst y", if_a.y, 0);
    check("midrst busy", busy_a, 0);
    check("midrst fcnt", fcnt_a, 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart valid", if_a.out_valid, 1);
    check("restart layer", if_a.layer, 0);
    check("restart x", if_a.x, 0);
    check("restart y", if_a.y, 0);

    // Single-layer config; park A in reset-cleared IDLE first
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    run_beats(1'b1, 1, 5, 2, 10, 1'b0, 1'b0);
    check("b end valid", if_b.out_valid, 0);
    check("b end busy", busy_b, 0);
    check("b fcnt", fcnt_b, 1);
    check("b end x", if_b.x, 0);
    check("b end y", if_b.y, 0);
    check("a idle during b", if_a.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_scan_gen.md
# pixel_scan_gen

Parametrised pixel/layer scan generator for the GPU engine's pixel-counter stage. It replaces the single-axis, layer-edge-clocked X counter with a fully synchronous generator. The generator walks layer (innermost), then X, then Y across a configurable frame, and presents each position over a valid/ready handshake. The compositing pipeline consumes its output, one beat per (layer, x, y) sample.

## Interface
- X_MAX, 1920, active pixels per line; x range 0..X_MAX-1
- Y_MAX, 1080, active lines per frame; y range 0..Y_MAX-1
- N_LAYERS, 4, layers per pixel; layer range 0..N_LAYERS-1
- FCNT_W, 16, frame counter width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- cont  in  1  continuous mode; sampled on the final beat of a frame
- out_ready  in  1  consumer accepts the current beat
- out_valid  out  1  current beat valid
- layer  out  LW  layer index; LW = max(1, $clog2(N_LAYERS))
- x  out  XW  pixel column; XW = $clog2(X_MAX)
- y  out  YW  line index; YW = $clog2(Y_MAX)
- line_end  out  1  beat is layer N_LAYERS-1 at x X_MAX-1
- frame_end  out  1  line_end and y == Y_MAX-1
- busy  out  1  FSM in RUN
- frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

## Operation
- FSM states: IDLE, RUN.
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - out_valid, layer, x, y, frame_cnt all become 0.
  - Reset has priority over every other input, including mid-frame.
- IDLE with start==1: go to RUN with out_valid=1 and (layer,x,y)=(0,0,0).
- IDLE with start==0: hold.
- A beat is accepted when out_valid && out_ready. Advance only on acceptance:
  - If layer < N_LAYERS-1: layer+1.
  - Else layer=0 and, if x < X_MAX-1: x+1.
  - Else x=0 and, if y < Y_MAX-1: y+1.
  - Else: final beat of the frame (see below).
- Final beat accepted:
  - frame_cnt increments.
  - cont==1: wrap to (0,0,0), stay in RUN, out_valid stays 1 with no bubble.
  - cont==0: go to IDLE, out_valid=0, coordinates return to 0.
- start is ignored while in RUN; a frame cannot be restarted except by reset.
- line_end and frame_end are combinational decodes of the registered layer/x/y. They are meaningful only while out_valid==1 and are forced to 0 when out_valid==0.
- N_LAYERS==1: layer is constant 0, and x advances on every accepted beat.
- Counter arithmetic:
  - Compares use the full-width constants X_MAX-1, Y_MAX-1 and N_LAYERS-1.
  - Counters never exceed their maxima.
  - Non-power-of-two maxima must wrap at the max, never at 2^W.

## Timing
- start sampled at edge k gives out_valid=1 with (0,0,0) after edge k.
- Throughput: one beat per cycle while out_ready==1.
- Frame length: X_MAX*Y_MAX*N_LAYERS accepted beats.
- With out_valid==1 && out_ready==0, all outputs hold stable. No beat is skipped or duplicated.
- busy equals (state==RUN). With cont==0, busy drops in the cycle after the final beat is accepted.
- frame_cnt updates in the same edge that accepts the final beat.

## Structure
- Shared package gpu_pkg:
  - Default X_MAX/Y_MAX constants.
  - State enum {IDLE, RUN}.
  - A width helper that returns max(1, $clog2(n)).
- Sub-module wrap_counter, parametrised by MAX and W:
  - Ports: inc, clr, value, at_max.
  - Instanced three times (layer, x, y).
  - Carry chain: the layer at_max gates the x inc, and the x at_max gates the y inc.
- The top level holds the FSM, the handshake, the flag decode and frame_cnt.

## Test plan
All scenarios use X_MAX=4, Y_MAX=3, N_LAYERS=2 unless stated.
- Reset: hold reset=0 for 3 cycles with start=1 -> out_valid=0, layer/x/y=0, frame_cnt=0, busy=0.
- Single frame: start pulse, out_ready=1, cont=0 ->
  - 24 consecutive beats in layer-x-y order.
  - line_end on beats 7, 15 and 23; frame_end only on beat 23.
  - out_valid=0 on the next cycle; frame_cnt=1.
- Backpressure: out_ready random at 50% -> identical 24-beat sequence, outputs stable on every stalled cycle.
- Continuous mode: cont=1, out_ready=1 -> beat 24 is (0,0,0) with no gap; frame_cnt=2 after 48 beats; busy stays 1.
- Reset mid-frame: assert reset=0 while at (layer,x,y)=(1,2,1) -> after that edge, IDLE with all outputs 0; a subsequent start restarts at (0,0,0).
- Config N_LAYERS=1, X_MAX=5, Y_MAX=2 -> layer stays 0; x runs 0..4 twice; frame_end on beat 9; no counter exceeds its maximum.
